// File: rtl/lcd_write_sequencer_pkg.sv
// ============================================================================
// lcd_write_sequencer_pkg : shared LCD state encodings, timing and config list
// Revision: 1.0
// ============================================================================
`default_nettype none

package lcd_write_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_POWER_WAIT = 4'd0,
    ST_INIT_SETUP = 4'd1,
    ST_INIT_PULSE = 4'd2,
    ST_INIT_WAIT  = 4'd3,
    ST_SETUP_HI   = 4'd4,
    ST_PULSE_HI   = 4'd5,
    ST_GAP        = 4'd6,
    ST_SETUP_LO   = 4'd7,
    ST_PULSE_LO   = 4'd8,
    ST_SETTLE     = 4'd9,
    ST_IDLE       = 4'd10
  } lcd_state_e;

  localparam int unsigned C_POWERON_WAIT = 750000;
  localparam int unsigned C_INIT_WAIT1   = 205000;
  localparam int unsigned C_INIT_WAIT2   = 5000;
  localparam int unsigned C_SETUP        = 2;
  localparam int unsigned C_PULSE        = 12;
  localparam int unsigned C_NIB_GAP      = 50;
  localparam int unsigned C_BYTE_WAIT    = 2000;
  localparam int unsigned C_CLEAR_WAIT   = 82000;

  localparam int unsigned C_CFG_LAST = 3;

  function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h28;
      2'd1:    return 8'h06;
      2'd2:    return 8'h0C;
      default: return 8'h01;
    endcase
  endfunction

  // A zero-length delay still occupies one cycle.
  function automatic logic [19:0] dly_load(input int unsigned n);
    return (n == 0) ? 20'd0 : 20'(n - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_write_sequencer_if.sv
// ============================================================================
// lcd_write_sequencer_if : byte request valid/ready handshake
// Revision: 1.0
// ============================================================================
`default_nettype none

interface lcd_write_sequencer_if;
  logic       iValid;
  logic       iRS;
  logic [7:0] iData;
  logic       oReady;

  modport master (output iValid, output iRS, output iData, input  oReady);
  modport slave  (input  iValid, input  iRS, input  iData, output oReady);
endinterface

`default_nettype wire

// File: rtl/lcd_write_sequencer_delay_counter.sv
// ============================================================================
// lcd_delay_counter : loadable 20-bit down-counter, done when it reaches zero
// Revision: 1.0
// ============================================================================
`default_nettype none

module lcd_delay_counter (
  input  wire logic        Clock,
  input  wire logic        Reset,
  input  wire logic        iLoad,
  input  wire logic [19:0] iValue,
  output logic             oDone
);

  logic [19:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (iLoad)
      count_d = iValue;
    else if (count_q != 20'd0)
      count_d = count_q - 20'd1;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign oDone = (count_q == 20'd0);

endmodule

`default_nettype wire

// File: rtl/lcd_write_sequencer.sv
// ============================================================================
// lcd_write_sequencer : LCD power-on init, config list and 4-bit byte writes
// Revision: 1.0
// ============================================================================
`default_nettype none

module lcd_write_sequencer
  import lcd_write_sequencer_pkg::*;
#(
  parameter int unsigned P_POWERON_WAIT = C_POWERON_WAIT,
  parameter int unsigned P_INIT_WAIT1   = C_INIT_WAIT1,
  parameter int unsigned P_INIT_WAIT2   = C_INIT_WAIT2,
  parameter int unsigned P_SETUP        = C_SETUP,
  parameter int unsigned P_PULSE        = C_PULSE,
  parameter int unsigned P_NIB_GAP      = C_NIB_GAP,
  parameter int unsigned P_BYTE_WAIT    = C_BYTE_WAIT,
  parameter int unsigned P_CLEAR_WAIT   = C_CLEAR_WAIT
) (
  input  wire logic              Clock,
  input  wire logic              Reset,
  lcd_write_sequencer_if.slave   hs,
  output logic                   oInitDone,
  output logic                   oLCD_Enabled,
  output logic                   oLCD_RegisterSelect,
  output logic                   oLCD_ReadWrite,
  output logic                   oLCD_StrataFlashControl,
  output logic [3:0]             oLCD_Data
);

  lcd_state_e  state_q, state_d;
  logic [1:0]  init_idx_q, init_idx_d;
  logic [1:0]  cfg_idx_q, cfg_idx_d;
  logic [7:0]  byte_q, byte_d;
  logic        rs_q, rs_d;
  logic        armed_q, armed_d;
  logic        init_done_q, init_done_d;
  logic        ready_q, ready_d;
  logic        e_q, e_d;
  logic [3:0]  data_q, data_d;
  logic        dly_load_en;
  logic [19:0] dly_value;
  logic        dly_done;

  lcd_delay_counter u_delay (
    .Clock  (Clock),
    .Reset  (Reset),
    .iLoad  (dly_load_en),
    .iValue (dly_value),
    .oDone  (dly_done)
  );

  always_comb begin
    state_d     = state_q;
    init_idx_d  = init_idx_q;
    cfg_idx_d   = cfg_idx_q;
    byte_d      = byte_q;
    rs_d        = rs_q;
    armed_d     = armed_q;
    init_done_d = init_done_q;

    case (state_q)
      // The counter comes out of reset at zero, so the first cycle only arms it.
      ST_POWER_WAIT: begin
        if (!armed_q)      armed_d = 1'b1;
        else if (dly_done) state_d = ST_INIT_SETUP;
      end
      ST_INIT_SETUP: if (dly_done) state_d = ST_INIT_PULSE;
      ST_INIT_PULSE: if (dly_done) state_d = ST_INIT_WAIT;
      ST_INIT_WAIT: begin
        if (dly_done) begin
          if (init_idx_q == 2'd3) begin
            cfg_idx_d = 2'd0;
            byte_d    = cfg_byte(2'd0);
            rs_d      = 1'b0;
            state_d   = ST_SETUP_HI;
          end else begin
            init_idx_d = init_idx_q + 2'd1;
            state_d    = ST_INIT_SETUP;
          end
        end
      end
      ST_SETUP_HI: if (dly_done) state_d = ST_PULSE_HI;
      ST_PULSE_HI: if (dly_done) state_d = ST_GAP;
      ST_GAP:      if (dly_done) state_d = ST_SETUP_LO;
      ST_SETUP_LO: if (dly_done) state_d = ST_PULSE_LO;
      ST_PULSE_LO: if (dly_done) state_d = ST_SETTLE;
      ST_SETTLE: begin
        if (dly_done) begin
          if (init_done_q) begin
            state_d = ST_IDLE;
          end else if (32'(cfg_idx_q) == C_CFG_LAST) begin
            init_done_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            cfg_idx_d = cfg_idx_q + 2'd1;
            byte_d    = cfg_byte(cfg_idx_q + 2'd1);
            state_d   = ST_SETUP_HI;
          end
        end
      end
      ST_IDLE: begin
        if (hs.iValid && ready_q) begin
          byte_d  = hs.iData;
          rs_d    = hs.iRS;
          state_d = ST_SETUP_HI;
        end
      end
      default: state_d = ST_POWER_WAIT;
    endcase

    dly_load_en = (state_d != state_q) || (state_q == ST_POWER_WAIT && !armed_q);
    case (state_d)
      ST_POWER_WAIT: dly_value = dly_load(P_POWERON_WAIT);
      ST_INIT_SETUP,
      ST_SETUP_HI,
      ST_SETUP_LO:   dly_value = dly_load(P_SETUP);
      ST_INIT_PULSE,
      ST_PULSE_HI,
      ST_PULSE_LO:   dly_value = dly_load(P_PULSE);
      ST_INIT_WAIT: begin
        case (init_idx_q)
          2'd0:    dly_value = dly_load(P_INIT_WAIT1);
          2'd1:    dly_value = dly_load(P_INIT_WAIT2);
          default: dly_value = dly_load(P_BYTE_WAIT);
        endcase
      end
      ST_GAP:        dly_value = dly_load(P_NIB_GAP);
      ST_SETTLE:     dly_value = (!rs_d && (byte_d inside {8'h01, 8'h02, 8'h03}))
                                 ? dly_load(P_CLEAR_WAIT) : dly_load(P_BYTE_WAIT);
      default:       dly_value = 20'd0;
    endcase

    // Pin values follow the next state so they register alongside it.
    e_d     = (state_d inside {ST_INIT_PULSE, ST_PULSE_HI, ST_PULSE_LO});
    ready_d = (state_d == ST_IDLE);
    data_d  = data_q;
    case (state_d)
      ST_INIT_SETUP, ST_INIT_PULSE, ST_INIT_WAIT:
        data_d = (init_idx_d == 2'd3) ? 4'h2 : 4'h3;
      ST_SETUP_HI, ST_PULSE_HI, ST_GAP:
        data_d = byte_d[7:4];
      ST_SETUP_LO, ST_PULSE_LO, ST_SETTLE:
        data_d = byte_d[3:0];
      default: data_d = data_q;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= ST_POWER_WAIT;
      init_idx_q  <= 2'd0;
      cfg_idx_q   <= 2'd0;
      byte_q      <= 8'h00;
      rs_q        <= 1'b0;
      armed_q     <= 1'b0;
      init_done_q <= 1'b0;
      ready_q     <= 1'b0;
      e_q         <= 1'b0;
      data_q      <= 4'h0;
    end else begin
      state_q     <= state_d;
      init_idx_q  <= init_idx_d;
      cfg_idx_q   <= cfg_idx_d;
      byte_q      <= byte_d;
      rs_q        <= rs_d;
      armed_q     <= armed_d;
      init_done_q <= init_done_d;
      ready_q     <= ready_d;
      e_q         <= e_d;
      data_q      <= data_d;
    end
  end

  assign hs.oReady               = ready_q;
  assign oInitDone               = init_done_q;
  assign oLCD_Enabled            = e_q;
  assign oLCD_RegisterSelect     = rs_q;
  assign oLCD_Data               = data_q;
  assign oLCD_ReadWrite          = 1'b0;
  assign oLCD_StrataFlashControl = 1'b1;

endmodule

`default_nettype wire

// File: tb/tb_lcd_write_sequencer.sv
// ============================================================================
// tb_lcd_write_sequencer : directed bench with nibble scoreboard on E strobes
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_lcd_write_sequencer;

  localparam int unsigned T_PULSE  = 3;
  localparam int          BUDGET   = 3000;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  logic oInitDone, oLCD_Enabled, oLCD_RegisterSelect, oLCD_ReadWrite, oLCD_StrataFlashControl;
  logic [3:0] oLCD_Data;

  lcd_write_sequencer_if hs ();

  lcd_write_sequencer #(
    .P_POWERON_WAIT (20), .P_INIT_WAIT1 (10), .P_INIT_WAIT2 (5), .P_SETUP (2),
    .P_PULSE (T_PULSE), .P_NIB_GAP (4), .P_BYTE_WAIT (6), .P_CLEAR_WAIT (15)
  ) dut (
    .Clock                   (Clock),
    .Reset                   (Reset),
    .hs                      (hs),
    .oInitDone               (oInitDone),
    .oLCD_Enabled            (oLCD_Enabled),
    .oLCD_RegisterSelect     (oLCD_RegisterSelect),
    .oLCD_ReadWrite          (oLCD_ReadWrite),
    .oLCD_StrataFlashControl (oLCD_StrataFlashControl),
    .oLCD_Data               (oLCD_Data)
  );

  always #5 Clock = ~Clock;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int pulses = 0;
  logic [4:0] sb[$];          // {rs, nibble} expected per E pulse

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard and E-width monitor, sampling on the falling edge.
  logic e_prev = 1'b0;
  int   width  = 0;
  always @(negedge Clock) begin
    if (!Reset) begin
      e_prev = 1'b0;
      width  = 0;
    end else begin
      if (oLCD_Enabled && !e_prev) begin
        pulses++;
        if (sb.size() == 0) check("unexpected_pulse", 32'(sb.size()), 32'd1);
        else check("nibble", {27'd0, oLCD_RegisterSelect, oLCD_Data}, {27'd0, sb.pop_front()});
        width = 0;
      end
      if (oLCD_Enabled) width++;
      if (!oLCD_Enabled && e_prev) check("e_width", width, T_PULSE);
      e_prev = oLCD_Enabled;
    end
  end

  task automatic tick();
    @(negedge Clock);
    #1;
  endtask

  task automatic push_byte(input logic rs, input logic [7:0] b);
    sb.push_back({rs, b[7:4]});
    sb.push_back({rs, b[3:0]});
  endtask

  task automatic push_init();
    logic [3:0] nib[4] = '{4'h3, 4'h3, 4'h3, 4'h2};
    foreach (nib[i]) sb.push_back({1'b0, nib[i]});
    push_byte(1'b0, 8'h28);
    push_byte(1'b0, 8'h06);
    push_byte(1'b0, 8'h0C);
    push_byte(1'b0, 8'h01);
  endtask

  task automatic wait_init();
    int n = 0;
    while (!oInitDone && n < BUDGET) begin tick(); n++; end
    check("init_done", oInitDone, 1'b1);
    check("init_ready", hs.oReady, 1'b1);
    check("init_pulses", pulses, 12);
    check("init_sb_empty", sb.size(), 0);
  endtask

  // Present a byte and wait for acceptance; returns the cycle of the accept edge.
  task automatic accept(input logic rs, input logic [7:0] b, input logic drop, output int at);
    int n = 0;
    hs.iValid = 1'b1; hs.iRS = rs; hs.iData = b;
    push_byte(rs, b);
    while (!hs.oReady && n < BUDGET) begin tick(); n++; end
    check("accept_ready", hs.oReady, 1'b1);
    tick();
    at = cyc;
    check("ready_drop", hs.oReady, 1'b0);
    if (drop) hs.iValid = 1'b0;
  endtask

  task automatic wait_settle(input int target, input int exp_settle);
    int n = 0;
    while (!(pulses == target && !oLCD_Enabled) && n < BUDGET) begin tick(); n++; end
    n = 0;
    while (!hs.oReady && n < BUDGET) begin n++; tick(); end
    check("settle_len", n, exp_settle);
    check("sb_empty", sb.size(), 0);
  endtask

  initial begin
    int a0, a1, base;
    hs.iValid = 1'b0; hs.iRS = 1'b0; hs.iData = 8'h00;
    repeat (3) tick();
    check("rst_ready", hs.oReady, 1'b0);
    check("rst_initdone", oInitDone, 1'b0);
    check("rst_e", oLCD_Enabled, 1'b0);
    check("rst_rs", oLCD_RegisterSelect, 1'b0);
    check("rst_data", oLCD_Data, 4'h0);
    check("rw_tie", oLCD_ReadWrite, 1'b0);
    check("sf_tie", oLCD_StrataFlashControl, 1'b1);

    // 1. power-on init and config list
    push_init();
    Reset = 1'b1;
    wait_init();

    // 2. data byte
    accept(1'b1, 8'h41, 1'b1, a0);
    wait_settle(14, 6);

    // 3. clear command and ordinary command
    accept(1'b0, 8'h01, 1'b1, a0);
    wait_settle(16, 15);
    accept(1'b0, 8'h80, 1'b1, a0);
    wait_settle(18, 6);

    // 4. back-to-back with iValid held
    accept(1'b1, 8'h48, 1'b0, a0);
    accept(1'b1, 8'h49, 1'b1, a1);
    check("b2b_period", a1 - a0, 1 + 2*2 + 2*3 + 4 + 6);
    wait_settle(22, 6);

    // 5. reset during the low-nibble pulse
    accept(1'b1, 8'h5A, 1'b1, a0);
    base = 0;
    while (!(pulses == 24 && oLCD_Enabled) && base < BUDGET) begin tick(); base++; end
    check("pulse_lo_seen", oLCD_Enabled, 1'b1);
    #1 Reset = 1'b0;
    #1;
    check("abort_e", oLCD_Enabled, 1'b0);
    check("abort_ready", hs.oReady, 1'b0);
    check("abort_initdone", oInitDone, 1'b0);
    sb.delete();
    repeat (2) tick();
    pulses = 0;
    push_init();
    Reset = 1'b1;
    wait_init();

    // 6. request held through init is taken on the first idle cycle
    tick();
    Reset = 1'b0;
    repeat (2) tick();
    pulses = 0;
    push_init();
    hs.iValid = 1'b1; hs.iRS = 1'b1; hs.iData = 8'h33;
    Reset = 1'b1;
    wait_init();
    push_byte(1'b1, 8'h33);
    tick();
    check("held_accept", hs.oReady, 1'b0);
    hs.iValid = 1'b0;
    wait_settle(14, 6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
